// File: rtl/adc_scan_scheduler.sv
// Conversion sequencer for the shared AD7908 frame engine: periodic ascending scans,
// one-shot priority requests, and realignment of the ADC's one-frame result lag.
module adc_scan_scheduler #(
    parameter int unsigned SCAN_DIV = 500000,
    parameter int unsigned NUM_CH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              frame_start,
    output logic [2:0]        frame_addr,
    input  logic              frame_busy,
    input  logic              frame_done,
    input  logic [15:0]       frame_data,
    input  logic              req_valid,
    input  logic [2:0]        req_ch,
    output logic              req_ready,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [7:0]        res_data,
    output logic              res_err,
    output logic              scan_overrun
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned AW    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_NEXT  = 2'd3
    } state_t;

    // Lowest enabled channel in a mask.
    function automatic logic [AW-1:0] lowest(input logic [NUM_CH-1:0] mask);
        logic [AW-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = AW'(i);
        end
        return r;
    endfunction

    // {found, addr} of the smallest enabled channel strictly above cur.
    function automatic logic [AW:0] next_above(input logic [NUM_CH-1:0] mask,
                                               input logic [AW-1:0]     cur);
        logic [AW:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) r = {1'b1, AW'(i)};
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_pend_q, tick_pend_d;
    logic              overrun_q, overrun_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [AW-1:0]     cur_q, cur_d;
    logic              last_q, last_d;
    logic              pend_v_q, pend_v_d;
    logic [AW-1:0]     pend_addr_q, pend_addr_d;
    logic              frame_start_q, frame_start_d;
    logic [AW-1:0]     frame_addr_q, frame_addr_d;
    logic              res_valid_q, res_valid_d;
    logic [AW-1:0]     res_ch_q, res_ch_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic              tick;
    logic              consume;
    logic [AW:0]       nxt;
    logic [AW-1:0]     low;
    logic              unused_frame_bits;

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign nxt  = next_above(mask_q, cur_q);
    assign low  = lowest(mask_q);
    assign unused_frame_bits = ^{frame_data[15:14], frame_data[2:0]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
        tick_pend_d   = tick_pend_q;
        overrun_d     = overrun_q;
        mask_d        = mask_q;
        cur_d         = cur_q;
        last_d        = last_q;
        pend_v_d      = pend_v_q;
        pend_addr_d   = pend_addr_q;
        frame_start_d = 1'b0;
        frame_addr_d  = frame_addr_q;
        res_valid_d   = 1'b0;
        res_ch_d      = res_ch_q;
        res_data_d    = res_data_q;
        res_err_d     = res_err_q;
        consume       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request is a one-channel scan: the channel then its flush repeat.
                if (req_valid) begin
                    mask_d   = NUM_CH'(1) << req_ch;
                    cur_d    = req_ch;
                    last_d   = 1'b0;
                    pend_v_d = 1'b0;
                    state_d  = S_ISSUE;
                end else if (tick_pend_q) begin
                    consume = 1'b1;
                    if (|ch_enable) begin
                        mask_d   = ch_enable;
                        cur_d    = lowest(ch_enable);
                        last_d   = 1'b0;
                        pend_v_d = 1'b0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!frame_busy) begin
                    frame_start_d = 1'b1;
                    frame_addr_d  = cur_q;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // Data returned now belongs to the previously programmed address.
                if (frame_done) begin
                    if (pend_v_q) begin
                        res_valid_d = 1'b1;
                        res_ch_d    = pend_addr_q;
                        res_data_d  = frame_data[10:3];
                        res_err_d   = (frame_data[13:11] != pend_addr_q);
                    end
                    pend_addr_d = frame_addr_q;
                    pend_v_d    = !last_q;
                    state_d     = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_q) begin
                    state_d = S_IDLE;
                end else begin
                    if (nxt[AW]) begin
                        cur_d = nxt[AW-1:0];
                    end else begin
                        cur_d  = low;
                        last_d = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (consume) tick_pend_d = 1'b0;
        if (tick) begin
            if (tick_pend_q) overrun_d   = 1'b1;
            else             tick_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tick_pend_q   <= 1'b0;
            overrun_q     <= 1'b0;
            mask_q        <= '0;
            cur_q         <= '0;
            last_q        <= 1'b0;
            pend_v_q      <= 1'b0;
            pend_addr_q   <= '0;
            frame_start_q <= 1'b0;
            frame_addr_q  <= '0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_data_q    <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tick_pend_q   <= tick_pend_d;
            overrun_q     <= overrun_d;
            mask_q        <= mask_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            pend_v_q      <= pend_v_d;
            pend_addr_q   <= pend_addr_d;
            frame_start_q <= frame_start_d;
            frame_addr_q  <= frame_addr_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_data_q    <= res_data_d;
            res_err_q     <= res_err_d;
        end
    end

    // Handshake must complete in the cycle the request is presented.
    assign req_ready    = req_valid && (state_q == S_IDLE) && !rst;
    assign frame_start  = frame_start_q;
    assign frame_addr   = frame_addr_q;
    assign res_valid    = res_valid_q;
    assign res_ch       = res_ch_q;
    assign res_data     = res_data_q;
    assign res_err      = res_err_q;
    assign scan_overrun = overrun_q;

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences conversions on the shared AD7908 SPI frame engine. Periodically scans all enabled channels in ascending order and services one-shot priority requests between scans. Undoes the ADC's one-frame result pipeline, where frame N returns the channel programmed in frame N-1. Emits a tagged result stream (channel, 8-bit code, address-mismatch flag) to downstream consumers (accel/CdS filters, telemetry).

Parameters:
SCAN_DIV, 500000, clk cycles between scan ticks (10 ms at 50 MHz); legal range 2..2^24-1
NUM_CH, 8, channel count; address width fixed at 3 bits

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
ch_enable  in  8  channel enable mask, sampled only at scan start
frame_start  out  1  one-cycle pulse: engine begins a 16-bit frame
frame_addr  out  3  channel address programmed into the frame; held from frame_start until frame_done
frame_busy  in  1  engine is mid-frame
frame_done  in  1  one-cycle pulse; frame_data valid on this cycle
frame_data  in  16  received frame: [13:11] address, [10:3] code
req_valid  in  1  one-shot priority conversion request
req_ch  in  3  requested channel
req_ready  out  1  request accepted this cycle (valid and ready)
res_valid  out  1  one-cycle result strobe
res_ch  out  3  channel the result belongs to
res_data  out  8  conversion code
res_err  out  1  frame_data[13:11] differed from res_ch
scan_overrun  out  1  sticky; set when a tick arrives while a tick is already pending

Behaviour:
- Reset values: frame_start=0, frame_addr=0, req_ready=0, res_valid=0, res_ch=0, res_data=0, res_err=0, scan_overrun=0. Internally: state=S_IDLE, tick counter=0, tick_pend=0, pend_v=0.
- Tick counter: counts 0..SCAN_DIV-1 and wraps. On the wrap it raises a tick.
  - If tick_pend=0, the tick sets tick_pend.
  - If tick_pend=1, scan_overrun is set.
  - scan_overrun clears only on rst.
- States: S_IDLE, S_ISSUE, S_WAIT, S_NEXT.
- S_IDLE:
  - If req_valid=1: assert req_ready for that cycle, latch req_ch, mode=REQ, frame list = {req_ch, req_ch}, go S_ISSUE. A request wins over tick_pend.
  - Else if tick_pend=1 and ch_enable!=0: clear tick_pend, latch mask, mode=SCAN, frame list = each enabled channel ascending, then one flush frame addressed to the lowest enabled channel. Go S_ISSUE.
  - Else if tick_pend=1 and ch_enable=0: clear tick_pend and stay in S_IDLE; no frames are issued.
  - At sequence start pend_v=0, so the first frame's returned data is always discarded.
- S_ISSUE: when frame_busy=0, drive frame_start=1 for exactly one cycle with frame_addr = current list entry, then go S_WAIT. While frame_busy=1, wait here without pulsing.
- S_WAIT: on frame_done:
  - If pend_v=1: on the next cycle res_valid=1, res_ch=pend_addr, res_data=frame_data[10:3], res_err=(frame_data[13:11]!=pend_addr).
  - Set pend_addr=frame_addr. Set pend_v=1 unless this was the flush frame (last list entry); the flush frame clears pend_v.
  - Go S_NEXT.
- S_NEXT: if list entries remain, advance and go S_ISSUE; otherwise go S_IDLE.
- Frame counts:
  - Scan with k enabled channels: k+1 frames and k results, in ascending channel order.
  - Priority request: 2 frames and exactly 1 result.
- req_ready is asserted only in S_IDLE. Requests during a sequence are held off, not dropped; the requester must hold req_valid.
- Ticks during a sequence are remembered (one deep) via tick_pend.
- res_valid never asserts on two consecutive cycles. res_ch, res_data and res_err hold their values between strobes.
- frame_done outside S_WAIT is ignored. A frame_done in the same cycle as frame_start is impossible by engine contract and is not handled.
- ch_enable changes mid-scan have no effect until the next scan start.
- rst mid-frame aborts immediately: all state returns to reset values, and the next sequence again discards its first result. The engine shares rst.

Test Plan:
- ch_enable=8'h03, SCAN_DIV=200, engine model returns {2'b00, addr_prev, code, 3'b0}. Required: 3 frames per scan with frame_addr 0,1,0; results (ch0, code0) then (ch1, code1) with res_err=0; no result from the first frame.
- ch_enable=8'h00 for 5 ticks. Required: no frame_start, no res_valid, scan_overrun=0.
- req_valid with req_ch=5 asserted in the same cycle tick_pend rises, ch_enable=8'h01. Required: req_ready that cycle; frames 5,5 then a single result ch5; afterwards the scan runs frames 0,0 and yields one result ch0.
- Engine returns frame_data[13:11]=3'd7 on the second frame of a 2-channel scan. Required: result ch0 with res_err=1 and res_data still taken from bits [10:3].
- SCAN_DIV=20, engine frame time 40 cycles, ch_enable=8'hFF. Required: scan_overrun=1 within the first scan and staying 1; scans run back-to-back with no lost ordering.
- rst asserted while in S_WAIT, released after 3 cycles. Required: all outputs 0 immediately; on the next scan the first frame's data is discarded.
